// File: rtl/ofs_fim_if_pkg.sv
// Shared interface types for the FIM RX pipeline: the AXIS beat structure
// carried between the PCIe RX stages (tvalid/tlast/tuser/tdata).
package ofs_fim_if_pkg;

   localparam int PCIE_RXS_TDATA_W = 128;
   localparam int PCIE_RXS_TUSER_W = 8;

   typedef struct packed {
      logic                        tvalid;
      logic                        tlast;
      logic [PCIE_RXS_TUSER_W-1:0] tuser;
      logic [PCIE_RXS_TDATA_W-1:0] tdata;
   } t_axis_pcie_rxs;

endpackage

// File: rtl/pcie_rxs_router_pkg.sv
// Router-local types: route and FSM state encodings, DW0 field offsets.
package pcie_rxs_router_pkg;

   typedef enum logic [1:0] {RT_REQ, RT_CPL, RT_DROP} t_rxs_route;
   typedef enum logic       {ST_SOP, ST_BODY}         t_rxs_state;

   // DW0 of channel 0: fmt in [31:29], type in [28:24]
   localparam int         DW0_FMT_LSB     = 29;
   localparam int         DW0_TYPE_LSB    = 24;
   localparam logic [1:0] MSG_TYPE_PREFIX = 2'b10;

endpackage

// File: rtl/pcie_rxs_out_slot.sv
// One-entry AXIS holding register. Loads when empty or when draining in the
// same cycle; holds tvalid and payload stable until the downstream handshake.
module pcie_rxs_out_slot
   import ofs_fim_if_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   input  logic           load,
   input  t_axis_pcie_rxs s_data,
   output t_axis_pcie_rxs m_if,
   input  logic           m_tready,
   output logic           can_load
);

   t_axis_pcie_rxs slot_q;
   t_axis_pcie_rxs slot_d;

   // next slot contents: capture on load, otherwise clear valid on drain
   always_comb begin
      slot_d = slot_q;
      if (load) begin
         slot_d        = s_data;
         slot_d.tvalid = 1'b1;
      end else if (m_tready) begin
         slot_d.tvalid = 1'b0;
      end
   end

   // slot register; reset empties it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) slot_q <= '0;
      else        slot_q <= slot_d;
   end

   assign m_if     = slot_q;
   assign can_load = ~slot_q.tvalid | m_tready;

endmodule

// File: rtl/pcie_rxs_tlp_router.sv
// Splits the RX TLP stream per packet into a completion port and a request
// port, each behind a one-entry output slot. Routing is decoded on the SOP
// beat and held until tlast.
// Optional feature: define PCIE_RXS_DROP_MSG_EN to discard Msg/MsgD TLPs and
// count them on drop_cnt.
module pcie_rxs_tlp_router
   import ofs_fim_if_pkg::*;
   import pcie_rxs_router_pkg::*;
#(
   parameter logic [4:0] CPL_TYPE       = 5'b01010,
   parameter bit         TREADY_RST_VAL = 1'b0
)(
   input  logic           clk,
   input  logic           rst_n,
   input  t_axis_pcie_rxs s_if,
   output logic           s_if_tready,
   output t_axis_pcie_rxs m_req_if,
   input  logic           m_req_tready,
   output t_axis_pcie_rxs m_cpl_if,
   input  logic           m_cpl_tready,
   output logic [31:0]    drop_cnt
);

   t_rxs_state state_q, state_d;
   t_rxs_route route_q, route_d;
   t_rxs_route sop_route;
   t_rxs_route target_route;
   logic [4:0] sop_type;
   logic       tready_int;
   logic       accept;
   logic       req_can_load, cpl_can_load;
   logic       req_load, cpl_load;

   assign sop_type = s_if.tdata[DW0_TYPE_LSB +: 5];

   // DW0 type decode, only meaningful on the SOP beat
   always_comb begin
      sop_route = RT_REQ;
      if (sop_type == CPL_TYPE) begin
         sop_route = RT_CPL;
      end
`ifdef PCIE_RXS_DROP_MSG_EN
      else if (sop_type[4:3] == MSG_TYPE_PREFIX) begin
         sop_route = RT_DROP;
      end
`endif
   end

   // target port and input ready; a stalled target blocks the input
   always_comb begin
      target_route = (state_q == ST_SOP) ? sop_route : route_q;
      case (target_route)
         RT_REQ:  tready_int = req_can_load;
         RT_CPL:  tready_int = cpl_can_load;
         default: tready_int = 1'b1;
      endcase
   end

   assign s_if_tready = rst_n ? tready_int : TREADY_RST_VAL;
   assign accept      = s_if.tvalid & s_if_tready;
   assign req_load    = accept & (target_route == RT_REQ);
   assign cpl_load    = accept & (target_route == RT_CPL);

   // packet FSM next state: latch route at SOP, return to SOP on tlast
   always_comb begin
      state_d = state_q;
      route_d = route_q;
      if (accept) begin
         if (state_q == ST_SOP) route_d = sop_route;
         state_d = s_if.tlast ? ST_SOP : ST_BODY;
      end
   end

   // packet FSM registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_SOP;
         route_q <= RT_REQ;
      end else begin
         state_q <= state_d;
         route_q <= route_d;
      end
   end

`ifdef PCIE_RXS_DROP_MSG_EN
   logic [31:0] drop_cnt_q, drop_cnt_d;

   // saturating count of dropped TLPs, bumped once per dropped SOP
   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (accept && (state_q == ST_SOP) && (sop_route == RT_DROP) && (drop_cnt_q != 32'hFFFF_FFFF))
         drop_cnt_d = drop_cnt_q + 32'd1;
   end

   // drop counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) drop_cnt_q <= '0;
      else        drop_cnt_q <= drop_cnt_d;
   end

   assign drop_cnt = drop_cnt_q;
`else
   assign drop_cnt = 32'd0;
`endif

   pcie_rxs_out_slot u_req_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (req_load),
      .s_data   (s_if),
      .m_if     (m_req_if),
      .m_tready (m_req_tready),
      .can_load (req_can_load)
   );

   pcie_rxs_out_slot u_cpl_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cpl_load),
      .s_data   (s_if),
      .m_if     (m_cpl_if),
      .m_tready (m_cpl_tready),
      .can_load (cpl_can_load)
   );

endmodule

// File: tb/tb_pcie_rxs_tlp_router.sv
// Self-checking bench for pcie_rxs_tlp_router: per-port scoreboards filled on
// accept, drained by a monitor on each output handshake.
module tb_pcie_rxs_tlp_router;
   import ofs_fim_if_pkg::*;

   localparam bit TRV = 1'b0;
   localparam int P_REQ  = 0;
   localparam int P_CPL  = 1;
   localparam int P_DROP = 2;

   logic           clk = 1'b0;
   logic           rst_n;
   t_axis_pcie_rxs s_if;
   logic           s_if_tready;
   t_axis_pcie_rxs m_req_if;
   logic           m_req_tready;
   t_axis_pcie_rxs m_cpl_if;
   logic           m_cpl_tready;
   logic [31:0]    drop_cnt;

   int n_cmp  = 0;
   int n_fail = 0;

   t_axis_pcie_rxs req_q[$];
   t_axis_pcie_rxs cpl_q[$];

   always #5 clk = ~clk;

   pcie_rxs_tlp_router #(
      .CPL_TYPE       (5'b01010),
      .TREADY_RST_VAL (TRV)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .s_if         (s_if),
      .s_if_tready  (s_if_tready),
      .m_req_if     (m_req_if),
      .m_req_tready (m_req_tready),
      .m_cpl_if     (m_cpl_if),
      .m_cpl_tready (m_cpl_tready),
      .drop_cnt     (drop_cnt)
   );

   // monitor: every output handshake must match the head of its scoreboard
   always @(negedge clk) begin
      t_axis_pcie_rxs exp;
      if (rst_n && m_req_if.tvalid && m_req_tready) begin
         n_cmp++;
         if (req_q.size() == 0) begin
            n_fail++;
            $display("FAIL req_unexpected: got tdata=%h, required no beat", m_req_if.tdata);
         end else begin
            exp = req_q.pop_front();
            if (m_req_if.tdata !== exp.tdata || m_req_if.tuser !== exp.tuser || m_req_if.tlast !== exp.tlast) begin
               n_fail++;
               $display("FAIL req_beat: got %h/%h/%b, required %h/%h/%b", m_req_if.tdata, m_req_if.tuser,
                        m_req_if.tlast, exp.tdata, exp.tuser, exp.tlast);
            end else
               $display("req beat tdata=%h tuser=%h tlast=%b ok", m_req_if.tdata, m_req_if.tuser, m_req_if.tlast);
         end
      end
      if (rst_n && m_cpl_if.tvalid && m_cpl_tready) begin
         n_cmp++;
         if (cpl_q.size() == 0) begin
            n_fail++;
            $display("FAIL cpl_unexpected: got tdata=%h, required no beat", m_cpl_if.tdata);
         end else begin
            exp = cpl_q.pop_front();
            if (m_cpl_if.tdata !== exp.tdata || m_cpl_if.tuser !== exp.tuser || m_cpl_if.tlast !== exp.tlast) begin
               n_fail++;
               $display("FAIL cpl_beat: got %h/%h/%b, required %h/%h/%b", m_cpl_if.tdata, m_cpl_if.tuser,
                        m_cpl_if.tlast, exp.tdata, exp.tuser, exp.tlast);
            end else
               $display("cpl beat tdata=%h tuser=%h tlast=%b ok", m_cpl_if.tdata, m_cpl_if.tuser, m_cpl_if.tlast);
         end
      end
   end

   function automatic logic [PCIE_RXS_TDATA_W-1:0] make_data(input logic [31:0] dw0);
      logic [PCIE_RXS_TDATA_W-1:0] d;
      d = '0;
      for (int w = 1; w < PCIE_RXS_TDATA_W / 32; w++) d[w*32 +: 32] = $urandom;
      d[31:0] = dw0;
      return d;
   endfunction

   // present one beat, wait (bounded) for acceptance, record expected output
   task automatic send_beat(input logic [31:0] dw0, input bit last, input int port, output int waits);
      t_axis_pcie_rxs b;
      b.tvalid = 1'b1;
      b.tlast  = last;
      b.tuser  = PCIE_RXS_TUSER_W'($urandom);
      b.tdata  = make_data(dw0);
      s_if     = b;
      waits    = 0;
      do begin
         @(negedge clk);
         waits++;
      end while (!s_if_tready && waits < 200);
      if (!s_if_tready) begin
         n_cmp++;
         n_fail++;
         $display("FAIL accept_timeout: dw0=%h not accepted after %0d cycles", dw0, waits);
      end else if (port == P_REQ) req_q.push_back(b);
      else if (port == P_CPL) cpl_q.push_back(b);
      @(posedge clk);
      #1;
      s_if.tvalid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      s_if = '0;
      s_if.tvalid = 1'b1;
      s_if.tdata  = make_data(32'h4A00_0000);
      m_req_tready = 1'b1;
      m_cpl_tready = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (m_req_if.tvalid !== 1'b0 || m_cpl_if.tvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_tvalid: got req=%b cpl=%b, required 0/0", m_req_if.tvalid, m_cpl_if.tvalid);
      end
      n_cmp++;
      if (s_if_tready !== TRV) begin
         n_fail++;
         $display("FAIL reset_tready: got %b, required %b", s_if_tready, TRV);
      end
      n_cmp++;
      if (drop_cnt !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_drop_cnt: got %0d, required 0", drop_cnt);
      end
      $display("reset checks done");
      @(posedge clk);
      #1;
      s_if.tvalid = 1'b0;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (m_req_if.tvalid !== 1'b0 || m_cpl_if.tvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset_idle: got req=%b cpl=%b, required 0/0", m_req_if.tvalid, m_cpl_if.tvalid);
      end
      idle(1);
   endtask

   task automatic test_route();
      int w;
      send_beat(32'h4A00_0001, 1'b1, P_CPL, w);
      @(negedge clk);
      n_cmp++;
      if (m_cpl_if.tvalid !== 1'b1 || m_req_if.tvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL route_latency: got cpl=%b req=%b at N+1, required 1/0", m_cpl_if.tvalid, m_req_if.tvalid);
      end
      idle(2);
   endtask

   task automatic test_multibeat();
      int w;
      logic [31:0] dws [4];
      dws[0] = 32'h6000_0004; dws[1] = $urandom; dws[2] = 32'h4A11_2233; dws[3] = $urandom;
      for (int i = 0; i < 4; i++) begin
         send_beat(dws[i], (i == 3), P_REQ, w);
         n_cmp++;
         if (w != 1) begin
            n_fail++;
            $display("FAIL multibeat_throughput: beat %0d waited %0d cycles, required 1", i, w);
         end
      end
      idle(3);
   endtask

   task automatic test_backpressure();
      int w;
      t_axis_pcie_rxs held;
      m_req_tready = 1'b0;
      send_beat(32'h6000_0001, 1'b1, P_REQ, w);      // parks in the REQ slot
      held = m_req_if;
      send_beat(32'h4A00_0002, 1'b1, P_CPL, w);      // CPL still flows
      s_if = '0;
      s_if.tvalid = 1'b1;
      s_if.tlast  = 1'b1;
      s_if.tdata  = make_data(32'h4000_0003);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if (s_if_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL hol_block: got s_if_tready=%b on cycle %0d, required 0", s_if_tready, i);
         end
      end
      n_cmp++;
      if (m_req_if !== held) begin
         n_fail++;
         $display("FAIL stall_stable: got %h, required %h", m_req_if, held);
      end
      n_cmp++;
      if (cpl_q.size() != 0) begin
         n_fail++;
         $display("FAIL cpl_bypass: got %0d pending cpl beats, required 0", cpl_q.size());
      end
      @(posedge clk);
      #1;
      m_req_tready = 1'b1;
      send_beat(32'h4000_0003, 1'b1, P_REQ, w);
      idle(3);
   endtask

   task automatic test_alternation();
      int w;
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) send_beat(32'h6000_0100 + i, 1'b1, P_REQ, w);
         else            send_beat(32'h4A00_0100 + i, 1'b1, P_CPL, w);
         n_cmp++;
         if (w != 1) begin
            n_fail++;
            $display("FAIL alternation_bubble: tlp %0d waited %0d cycles, required 1", i, w);
         end
      end
      idle(3);
   endtask

   task automatic test_drop();
      int w;
`ifdef PCIE_RXS_DROP_MSG_EN
      send_beat(32'h3400_0000, 1'b0, P_DROP, w);
      send_beat($urandom, 1'b1, P_DROP, w);
      idle(2);
      n_cmp++;
      if (drop_cnt !== 32'd1) begin
         n_fail++;
         $display("FAIL drop_cnt: got %0d, required 1", drop_cnt);
      end
`else
      send_beat(32'h3400_0000, 1'b0, P_REQ, w);
      send_beat($urandom, 1'b1, P_REQ, w);
      idle(2);
      n_cmp++;
      if (drop_cnt !== 32'd0) begin
         n_fail++;
         $display("FAIL drop_cnt: got %0d, required 0", drop_cnt);
      end
`endif
      idle(2);
   endtask

   task automatic test_reset_mid_packet();
      int w;
      send_beat(32'h6000_0003, 1'b0, P_REQ, w);      // SOP of a 3-beat REQ
      @(negedge clk);                                  // beat drains here
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      idle(1);
      send_beat(32'h4A00_0009, 1'b1, P_CPL, w);        // must be decoded as SOP
      idle(3);
   endtask

   initial begin
      test_reset();
      test_route();
      test_multibeat();
      test_backpressure();
      test_alternation();
      test_drop();
      test_reset_mid_packet();
      n_cmp++;
      if (req_q.size() != 0 || cpl_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got req=%0d cpl=%0d pending, required 0/0", req_q.size(), cpl_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
